// File: rtl/pipe_stage_pkg.sv
// Shared types for the two-entry skid pipeline stage.
// The statistics counters are enabled by the PIPE_STAGE_STATS_EN macro.
package pipe_stage_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload holding register of the skid stage.
// It loads only when enabled and clears to zero on reset.
module pipe_stage_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline register with registered in_ready.
// Optional stall/flush statistics are built when PIPE_STAGE_STATS_EN is defined.
module pipe_skid_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 3,
  parameter int AW_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [AW_W-1:0]         in_aw,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [AW_W-1:0]         out_aw,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [STAT_W-1:0]       stall_cnt,
  output logic [STAT_W-1:0]       flush_cnt,
  output logic [1:0]              dbg_state
);

  localparam int DW     = LANES * DATA_W;
  localparam int BEAT_W = DW + AW_W + CTRL_W;

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; in_ready is a flop so it never depends on out_ready in the same cycle.

  state_t              state_q, state_d;
  logic                in_ready_q, out_valid_q;
  logic                accept, drain;
  logic                main_load, skid_load;
  logic [BEAT_W-1:0]   in_beat, main_d, main_q, skid_q;

  assign in_beat = {in_data, in_aw, in_ctrl};
  assign accept  = in_valid & in_ready_q;
  assign drain   = out_valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_beat;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d   = ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  pipe_stage_entry #(.W(BEAT_W)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_stage_entry #(.W(BEAT_W)) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .load  (skid_load),
    .d     (in_beat),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q[BEAT_W-1 -: DW];
  assign out_aw    = main_q[CTRL_W +: AW_W];
  // A bubble must never carry write enables downstream.
  assign out_ctrl  = out_valid_q ? main_q[CTRL_W-1:0] : '0;
  assign dbg_state = state_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: the stage is modelled as a two-deep FIFO queue.
// Counter expectations follow PIPE_STAGE_STATS_EN when it is defined.
module tb_pipe_skid_stage;
  import pipe_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int LANES  = 3;
  localparam int AW_W   = 5;
  localparam int CTRL_W = 4;
  localparam int DW     = LANES * DATA_W;
  localparam int BEAT_W = DW + AW_W + CTRL_W;
`ifdef PIPE_STAGE_STATS_EN
  localparam int STALL_N = 70000;
`else
  localparam int STALL_N = 200;
`endif

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [AW_W-1:0]   in_aw;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [AW_W-1:0]   out_aw;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [BEAT_W-1:0] exp_q[$];
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_skid_stage #(
    .DATA_W(DATA_W), .LANES(LANES), .AW_W(AW_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_aw     (in_aw),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_aw    (out_aw),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stat_exp(int v);
`ifdef PIPE_STAGE_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every visible output against the FIFO model
  task automatic check_outputs();
    int n;
    logic [BEAT_W-1:0] h;
    state_t es;
    n  = exp_q.size();
    es = (n == 0) ? EMPTY : ((n == 1) ? ONE : TWO);
    check("in_ready", in_ready, n < 2);
    check("out_valid", out_valid, n > 0);
    check("state", dbg_state, es);
    if (n > 0) begin
      h = exp_q[0];
      check("out_data", out_data, h[BEAT_W-1 -: DW]);
      check("out_aw", out_aw, h[CTRL_W +: AW_W]);
      check("out_ctrl", out_ctrl, h[CTRL_W-1:0]);
    end else begin
      check("bubble_ctrl", out_ctrl, 0);
    end
    check("stall_cnt", stall_cnt, stat_exp(exp_stall));
    check("flush_cnt", flush_cnt, stat_exp(exp_flush));
  endtask

  task automatic model_step();
    bit acc, drn;
    acc = in_valid && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && out_ready;
    if ((exp_q.size() > 0) && !out_ready && (exp_stall < 65535)) exp_stall++;
    if (flush && (exp_flush < 65535)) exp_flush++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_data, in_aw, in_ctrl});
    end
  endtask

  // driver tasks: inputs change at the falling edge, outputs checked there too
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [AW_W-1:0] aw);
    in_valid = v;
    in_aw    = aw;
    in_data  = {$urandom(), $urandom(), $urandom()};
    in_ctrl  = CTRL_W'($urandom_range(1, 15));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_aw", out_aw, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    exp_q.delete();
    exp_stall = 0;
    exp_flush = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'd31);
    #1;
    apply_reset();

    // first beat after reset: one-cycle latency
    drive(1'b1, 5'd1);
    in_data[DATA_W-1:0] = 32'h0000_1234;
    cycle();
    drive(1'b0, 5'd0);
    check("lat_valid", out_valid, 1);
    check("lat_lane0", out_data[DATA_W-1:0], 32'h0000_1234);
    cycle();
    cycle();

    // ten back-to-back beats with downstream always ready
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, AW_W'(i));
      cycle();
    end
    drive(1'b0, 5'd0);
    repeat (2) cycle();

    // fill both entries, hold a third beat upstream, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 5'd3);
    cycle();
    drive(1'b1, 5'd4);
    cycle();
    drive(1'b1, 5'd5);
    check("two_in_ready", in_ready, 0);
    cycle();
    out_ready = 1'b1;
    check("two_head_aw", out_aw, 3);
    cycle();
    check("drain_aw4", out_aw, 4);
    cycle();
    drive(1'b0, 5'd0);
    check("drain_aw5", out_aw, 5);
    repeat (2) cycle();

    // flush while full with an incoming beat
    out_ready = 1'b0;
    drive(1'b1, 5'd7);
    cycle();
    drive(1'b1, 5'd8);
    cycle();
    drive(1'b1, 5'd9);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_ready", in_ready, 1);
    repeat (3) cycle();

    // reset in the middle of holding beats
    out_ready = 1'b0;
    drive(1'b1, 5'd11);
    cycle();
    drive(1'b1, 5'd12);
    cycle();
    apply_reset();
    out_ready = 1'b1;
    drive(1'b0, 5'd0);
    repeat (2) cycle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), AW_W'($urandom()));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // long stall to saturate the stall counter, then two flushes
    apply_reset();
    out_ready = 1'b0;
    drive(1'b1, 5'd21);
    cycle();
    drive(1'b0, 5'd0);
    for (int i = 0; i < STALL_N; i++) cycle();
    check("stall_final", stall_cnt, stat_exp((STALL_N >= 65535) ? 65535 : STALL_N));
    flush = 1'b1;
    cycle();
    cycle();
    flush = 1'b0;
    cycle();
    check("flush_final", flush_cnt, stat_exp(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
